// File: rtl/ecg_window_feeder_if.sv
// Stream-in / window-out bundle between the sample source, ecg_window_feeder and the node layer.
// The slave modport is the feeder side; the master modport drives samples and reads windows.
interface ecg_window_feeder_if #(
    parameter int DEPTH = 30
);
    logic               frame_start;
    logic [7:0]         din;
    logic               din_valid;
    logic               din_ready;
    logic [8*DEPTH-1:0] win_out;
    logic               win_valid;
    logic [15:0]        win_idx;
    logic               res_valid;
    logic [15:0]        res_idx;

    modport master (
        output frame_start, din, din_valid,
        input  din_ready, win_out, win_valid, win_idx, res_valid, res_idx
    );

    modport slave (
        input  frame_start, din, din_valid,
        output din_ready, win_out, win_valid, win_idx, res_valid, res_idx
    );
endinterface

// File: rtl/ecg_window_feeder.sv
// Serial 8-bit sample stream to DEPTH-wide sliding window for the node layer, with window/result strobes.
// Optional build macro ECG_WIN_ZERO_PAD_EN: emit zero-padded windows every STRIDE accepts while filling.
module ecg_window_feeder #(
    parameter int DEPTH   = 30,
    parameter int STRIDE  = 1,
    parameter int LATENCY = 3
) (
    input  logic               clk,
    input  logic               reset,
    ecg_window_feeder_if.slave bus
);
    localparam int FW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STRIDE + 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN
    } state_e;

    state_e             state_q, state_d;
    logic [8*DEPTH-1:0] win_q, win_d;
    logic [FW-1:0]      fill_cnt_q, fill_cnt_d;
    logic [SW-1:0]      stride_cnt_q, stride_cnt_d;
    logic [15:0]        win_idx_q, win_idx_d;
    logic               win_valid_q, win_valid_d;
    logic               din_ready_q;
    logic               res_valid_q [LATENCY];
    logic [15:0]        res_idx_q   [LATENCY];

    logic accept;
    assign accept = bus.din_valid & din_ready_q;

    always_comb begin
        // NOTE: every next-state value is defaulted first, so no branch can leave one unassigned and infer a latch.
        state_d      = state_q;
        win_d        = win_q;
        fill_cnt_d   = fill_cnt_q;
        stride_cnt_d = stride_cnt_q;
        win_idx_d    = win_valid_q ? win_idx_q + 16'd1 : win_idx_q;
        win_valid_d  = 1'b0;

        // A new frame clears first; a sample accepted in the same cycle then lands on the cleared window.
        if (bus.frame_start) begin
            state_d      = FILL;
            win_d        = '0;
            fill_cnt_d   = '0;
            stride_cnt_d = '0;
            win_idx_d    = '0;
        end

        if (accept) begin
            win_d = {bus.din, win_d[8*DEPTH-1:8]};
            if (state_d == FILL) begin
                fill_cnt_d = fill_cnt_d + FW'(1);
                if (fill_cnt_d == FW'(DEPTH)) begin
                    state_d      = RUN;
                    stride_cnt_d = '0;
                    win_valid_d  = 1'b1;
                end
`ifdef ECG_WIN_ZERO_PAD_EN
                else if (stride_cnt_d == SW'(STRIDE - 1)) begin
                    stride_cnt_d = '0;
                    win_valid_d  = 1'b1;
                end else begin
                    stride_cnt_d = stride_cnt_d + SW'(1);
                end
`endif
            end else if (stride_cnt_d == SW'(STRIDE - 1)) begin
                stride_cnt_d = '0;
                win_valid_d  = 1'b1;
            end else begin
                stride_cnt_d = stride_cnt_d + SW'(1);
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            din_ready_q  <= 1'b0;
            win_q        <= '0;
            fill_cnt_q   <= '0;
            stride_cnt_q <= '0;
            win_idx_q    <= '0;
            win_valid_q  <= 1'b0;
            // NOTE: the delay line is reset as well, so results in flight are dropped rather than emitted later.
            for (int i = 0; i < LATENCY; i++) begin
                res_valid_q[i] <= 1'b0;
                res_idx_q[i]   <= '0;
            end
        end else begin
            state_q        <= state_d;
            din_ready_q    <= (state_d != IDLE);
            win_q          <= win_d;
            fill_cnt_q     <= fill_cnt_d;
            stride_cnt_q   <= stride_cnt_d;
            win_idx_q      <= win_idx_d;
            win_valid_q    <= win_valid_d;
            res_valid_q[0] <= win_valid_q;
            res_idx_q[0]   <= win_idx_q;
            for (int i = 1; i < LATENCY; i++) begin
                res_valid_q[i] <= res_valid_q[i-1];
                res_idx_q[i]   <= res_idx_q[i-1];
            end
        end
    end

    assign bus.din_ready = din_ready_q;
    assign bus.win_out   = win_q;
    assign bus.win_valid = win_valid_q;
    assign bus.win_idx   = win_idx_q;
    assign bus.res_valid = res_valid_q[LATENCY-1];
    assign bus.res_idx   = res_idx_q[LATENCY-1];
endmodule

// File: tb/tb_ecg_window_feeder.sv
// Directed bench for ecg_window_feeder: a STRIDE=1 and a STRIDE=4 instance share clock, reset and a vector table.
// Hand-written sequences cover frame restart mid-run, asynchronous reset with results in flight, and zero padding.
module tb_ecg_window_feeder;
    localparam int DEPTH   = 30;
    localparam int LATENCY = 3;
    localparam int NV      = 43;
`ifdef ECG_WIN_ZERO_PAD_EN
    localparam bit ZERO_PAD = 1'b1;
`else
    localparam bit ZERO_PAD = 1'b0;
`endif

    logic clk;
    logic reset;

    ecg_window_feeder_if #(.DEPTH(DEPTH)) bus1 ();
    ecg_window_feeder_if #(.DEPTH(DEPTH)) bus4 ();

    ecg_window_feeder #(.DEPTH(DEPTH), .STRIDE(1), .LATENCY(LATENCY)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    ecg_window_feeder #(.DEPTH(DEPTH), .STRIDE(4), .LATENCY(LATENCY)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fs;
        logic        dv;
        logic [7:0]  din;
        logic [7:0]  slot0;
        logic [7:0]  slot29;
        logic        wv1;
        logic [15:0] idx1;
        logic        rv1;
        logic [15:0] ridx1;
        logic        wv4;
        logic [15:0] idx4;
        logic        rv4;
        logic [15:0] ridx4;
    } vec_t;

    vec_t vecs [NV];
    int   checks;
    int   errors;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic fs, input logic dv, input logic [7:0] d);
        bus1.frame_start = fs;
        bus1.din_valid   = dv;
        bus1.din         = d;
        bus4.frame_start = fs;
        bus4.din_valid   = dv;
        bus4.din         = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int                 cnt1;
        int                 cnt4;
        int                 last;
        int                 e1_idx;
        logic [8*DEPTH-1:0] exp_win;

        checks = 0;
        errors = 0;

        // Vector table: frame_start, samples 1..38, then four idle cycles.
        cnt1 = 0;
        cnt4 = 0;
        for (int k = 0; k < NV; k++) begin
            vecs[k].fs  = (k == 0);
            vecs[k].dv  = (k >= 1 && k <= 38);
            vecs[k].din = vecs[k].dv ? 8'(k) : 8'h00;
            last = (k > 38) ? 38 : k;
            vecs[k].slot29 = 8'(last);
            vecs[k].slot0  = (last >= 30) ? 8'(last - 29) : 8'h00;
            vecs[k].wv1 = vecs[k].dv && (ZERO_PAD || k >= 30);
            vecs[k].wv4 = vecs[k].dv && ((k == 30) || (k > 30 && (k - 30) % 4 == 0) ||
                                         (ZERO_PAD && k < 30 && k % 4 == 0));
            vecs[k].idx1 = 16'(cnt1);
            vecs[k].idx4 = 16'(cnt4);
            if (vecs[k].wv1) cnt1++;
            if (vecs[k].wv4) cnt4++;
            vecs[k].rv1   = (k >= 3) ? vecs[k-3].wv1  : 1'b0;
            vecs[k].ridx1 = (k >= 3) ? vecs[k-3].idx1 : 16'h0000;
            vecs[k].rv4   = (k >= 3) ? vecs[k-3].wv4  : 1'b0;
            vecs[k].ridx4 = (k >= 3) ? vecs[k-3].idx4 : 16'h0000;
        end

        // Reset state, observed before any clock edge.
        reset = 1'b0;
        drive(1'b0, 1'b0, 8'h00);
        #1 reset = 1'b1;
        #1;
        check("reset win_out",   bus1.win_out,   '0);
        check("reset win_valid", bus1.win_valid, '0);
        check("reset win_idx",   bus1.win_idx,   '0);
        check("reset res_valid", bus1.res_valid, '0);
        check("reset res_idx",   bus1.res_idx,   '0);
        check("reset din_ready", bus1.din_ready, '0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        step();
        check("idle din_ready", bus1.din_ready, '0);

        for (int k = 0; k < NV; k++) begin
            drive(vecs[k].fs, vecs[k].dv, vecs[k].din);
            step();
            check($sformatf("v%0d slot0", k),      bus1.win_out[7:0],     vecs[k].slot0);
            check($sformatf("v%0d slot29", k),     bus1.win_out[239:232], vecs[k].slot29);
            check($sformatf("v%0d s1 wv", k),      bus1.win_valid,        vecs[k].wv1);
            check($sformatf("v%0d s1 idx", k),     bus1.win_idx,          vecs[k].idx1);
            check($sformatf("v%0d s1 rv", k),      bus1.res_valid,        vecs[k].rv1);
            if (vecs[k].rv1) check($sformatf("v%0d s1 ridx", k), bus1.res_idx, vecs[k].ridx1);
            check($sformatf("v%0d s4 slot29", k),  bus4.win_out[239:232], vecs[k].slot29);
            check($sformatf("v%0d s4 wv", k),      bus4.win_valid,        vecs[k].wv4);
            check($sformatf("v%0d s4 idx", k),     bus4.win_idx,          vecs[k].idx4);
            check($sformatf("v%0d s4 rv", k),      bus4.res_valid,        vecs[k].rv4);
            if (vecs[k].rv4) check($sformatf("v%0d s4 ridx", k), bus4.res_idx, vecs[k].ridx4);
            check($sformatf("v%0d din_ready", k),  bus1.din_ready,        1'b1);
        end

        // One more window in RUN, then frame_start with a simultaneous accept while it is in flight.
        drive(1'b0, 1'b0, 8'h00);
        bus1.din_valid = 1'b1;
        bus1.din       = 8'hAA;
        e1_idx = cnt1;
        step();
        check("restart pre wv",  bus1.win_valid, 1'b1);
        check("restart pre idx", bus1.win_idx,   16'(e1_idx));
        bus1.frame_start = 1'b1;
        bus1.din         = 8'h55;
        step();
        exp_win = '0;
        exp_win[239:232] = 8'h55;
        check("restart window", bus1.win_out,   exp_win);
        check("restart wv",     bus1.win_valid, ZERO_PAD);
        check("restart idx",    bus1.win_idx,   '0);
        check("restart rv e2",  bus1.res_valid, '0);
        bus1.frame_start = 1'b0;
        bus1.din_valid   = 1'b0;
        step();
        check("restart rv e3",  bus1.res_valid, '0);
        step();
        check("inflight rv",    bus1.res_valid, 1'b1);
        check("inflight ridx",  bus1.res_idx,   16'(e1_idx));

        // Refill: 29 more accepts complete the window that starts with 0x55.
        for (int i = 0; i < 29; i++) begin
            bus1.din_valid = 1'b1;
            bus1.din       = 8'(i + 1);
            step();
            check($sformatf("refill%0d wv", i),  bus1.win_valid, ZERO_PAD || (i == 28));
            check($sformatf("refill%0d idx", i), bus1.win_idx,   ZERO_PAD ? 16'(i + 1) : 16'h0000);
        end
        check("refill slot0",  bus1.win_out[7:0],     8'h55);
        check("refill slot29", bus1.win_out[239:232], 8'd29);

        // Asynchronous reset between that window's win_valid and its res_valid.
        #1 reset = 1'b1;
        #1;
        check("areset win_out",   bus1.win_out,   '0);
        check("areset win_valid", bus1.win_valid, '0);
        check("areset win_idx",   bus1.win_idx,   '0);
        check("areset res_valid", bus1.res_valid, '0);
        check("areset res_idx",   bus1.res_idx,   '0);
        check("areset din_ready", bus1.din_ready, '0);
        @(negedge clk) reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("post reset%0d rv", i),    bus1.res_valid, '0);
            check($sformatf("post reset%0d wv", i),    bus1.win_valid, '0);
            check($sformatf("post reset%0d ready", i), bus1.din_ready, '0);
        end

        // Single sample after frame_start: a window only when zero padding is built in.
        bus1.din_valid   = 1'b0;
        bus1.frame_start = 1'b1;
        step();
        check("pad ready", bus1.din_ready, 1'b1);
        bus1.frame_start = 1'b0;
        bus1.din_valid   = 1'b1;
        bus1.din         = 8'h7F;
        step();
        exp_win = '0;
        exp_win[239:232] = 8'h7F;
        check("pad window", bus1.win_out,   exp_win);
        check("pad wv",     bus1.win_valid, ZERO_PAD);
        check("pad idx",    bus1.win_idx,   '0);
        bus1.din_valid = 1'b0;
        step();
        check("pad hold wv",     bus1.win_valid, '0);
        check("pad hold window", bus1.win_out,   exp_win);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
